// File: rtl/mark_shift_sequencer.sv
// rtl/mark_shift_sequencer.sv - expands a ruler mark set into one shifter request per mark
// Framing tags ride a delay line matched to the downstream shifter latency.
module mark_shift_sequencer #(
   parameter int WIDTH         = 13,
   parameter int SHIFT_LATENCY = ($clog2(WIDTH) + 1) / 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           ruler,
   input  logic                       rulerValid,
   output logic                       rulerReady,
   output logic [WIDTH-1:0]           shiftIn,
   output logic [$clog2(WIDTH)-1:0]   shiftAmount,
   output logic                       shiftValid,
   output logic                       tagValid,
   output logic                       tagFirst,
   output logic                       tagLast,
   output logic                       dropped
);

   localparam int AW = $clog2(WIDTH);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   held;
   logic [WIDTH-1:0]   held_next;
   logic [WIDTH-1:0]   pending;
   logic [WIDTH-1:0]   pending_next;
   logic               first_pending;
   logic               first_pending_next;

   logic [AW-1:0]      low_idx;
   logic [WIDTH-1:0]   pending_cleared;
   logic               pending_one;
   logic               accept;
   logic               ruler_zero;
   logic               beat_now;
   logic               beat_is_last;

   logic               beat_first;
   logic               beat_last;

   logic [SHIFT_LATENCY-1:0] tag_valid_pipe;
   logic [SHIFT_LATENCY-1:0] tag_first_pipe;
   logic [SHIFT_LATENCY-1:0] tag_last_pipe;

   always_comb begin
      low_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pending[i]) begin
            low_idx = AW'(i);
         end
      end
   end

   // x & (x-1) strips the lowest set bit; empty result means it was the only one.
   assign pending_cleared = pending & (pending - WIDTH'(1));
   assign pending_one     = (pending != '0) && (pending_cleared == '0);
   assign beat_is_last    = (pending_cleared == '0);
   assign beat_now        = (state == SCAN);
   assign ruler_zero      = (ruler == '0);

   assign rulerReady = reset && ((state == IDLE) || ((state == SCAN) && pending_one));
   assign accept     = rulerValid && rulerReady;

   always_comb begin
      state_next         = state;
      held_next          = held;
      pending_next       = pending;
      first_pending_next = first_pending;
      case (state)
         IDLE: begin
            if (accept && !ruler_zero) begin
               held_next          = ruler;
               pending_next       = ruler;
               first_pending_next = 1'b1;
               state_next         = SCAN;
            end
         end
         SCAN: begin
            pending_next       = pending_cleared;
            first_pending_next = 1'b0;
            if (beat_is_last) begin
               // Chaining a new ruler onto the last beat keeps the shifter busy every cycle.
               if (accept && !ruler_zero) begin
                  held_next          = ruler;
                  pending_next       = ruler;
                  first_pending_next = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         held          <= '0;
         pending       <= '0;
         first_pending <= 1'b0;
      end else begin
         state         <= state_next;
         held          <= held_next;
         pending       <= pending_next;
         first_pending <= first_pending_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         shiftIn     <= '0;
         shiftAmount <= '0;
         shiftValid  <= 1'b0;
         beat_first  <= 1'b0;
         beat_last   <= 1'b0;
         dropped     <= 1'b0;
      end else begin
         shiftValid <= beat_now;
         if (beat_now) begin
            shiftIn     <= held;
            shiftAmount <= low_idx;
         end
         beat_first <= beat_now && first_pending;
         beat_last  <= beat_now && beat_is_last;
         dropped    <= accept && ruler_zero;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         tag_valid_pipe <= '0;
         tag_first_pipe <= '0;
         tag_last_pipe  <= '0;
      end else begin
         tag_valid_pipe[0] <= shiftValid;
         tag_first_pipe[0] <= beat_first;
         tag_last_pipe[0]  <= beat_last;
         for (int i = 1; i < SHIFT_LATENCY; i++) begin
            tag_valid_pipe[i] <= tag_valid_pipe[i-1];
            tag_first_pipe[i] <= tag_first_pipe[i-1];
            tag_last_pipe[i]  <= tag_last_pipe[i-1];
         end
      end
   end

   assign tagValid = tag_valid_pipe[SHIFT_LATENCY-1];
   assign tagFirst = tag_first_pipe[SHIFT_LATENCY-1];
   assign tagLast  = tag_last_pipe[SHIFT_LATENCY-1];

endmodule

// File: tb/tb_mark_shift_sequencer.sv
// tb/tb_mark_shift_sequencer.sv - randomized and directed bench for mark_shift_sequencer
// A queue of outstanding beats and a tag history queue form the reference model.
module tb_mark_shift_sequencer;

   localparam int W = 13;
   localparam int L = ($clog2(W) + 1) / 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  ruler;
   logic          rulerValid;
   logic          rulerReady;
   logic [W-1:0]  shiftIn;
   logic [3:0]    shiftAmount;
   logic          shiftValid;
   logic          tagValid;
   logic          tagFirst;
   logic          tagLast;
   logic          dropped;

   mark_shift_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .ruler(ruler), .rulerValid(rulerValid),
      .rulerReady(rulerReady), .shiftIn(shiftIn), .shiftAmount(shiftAmount),
      .shiftValid(shiftValid), .tagValid(tagValid), .tagFirst(tagFirst),
      .tagLast(tagLast), .dropped(dropped)
   );

   always #5 clk = ~clk;

   typedef struct {logic [W-1:0] held; int amt; bit first; bit last;} beat_t;
   typedef struct {bit v; bit f; bit l;} tag_t;

   beat_t        q[$];
   tag_t         hist[$];
   bit           exp_sv, exp_bf, exp_bl, exp_drop, exp_tv, exp_tf, exp_tl;
   logic [W-1:0] exp_in;
   int           exp_amt;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int obs_amt[$];
   int obs_bcyc[$];
   int obs_tf[$];
   int obs_tl[$];
   int obs_tcyc[$];
   int obs_drop, obs_rlow;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   task automatic clear_logs();
      obs_amt.delete(); obs_bcyc.delete(); obs_tf.delete(); obs_tl.delete(); obs_tcyc.delete();
      obs_drop = 0;
      obs_rlow = 0;
   endtask

   task automatic model_reset();
      tag_t z;
      z = '{0, 0, 0};
      q.delete();
      hist.delete();
      for (int i = 0; i < L - 1; i++) hist.push_back(z);
      exp_sv = 0; exp_bf = 0; exp_bl = 0; exp_drop = 0;
      exp_tv = 0; exp_tf = 0; exp_tl = 0;
      exp_in = '0; exp_amt = 0;
   endtask

   task automatic cycle(input logic rst, input logic v, input logic [W-1:0] r);
      beat_t b;
      tag_t  pre, t;
      bit    m_ready, acc;
      int    lo, hi;
      @(negedge clk);
      cyc++;
      chk("shiftValid", shiftValid, exp_sv);
      chk("shiftIn", shiftIn, exp_in);
      chk("shiftAmount", shiftAmount, exp_amt);
      chk("tagValid", tagValid, exp_tv);
      chk("dropped", dropped, exp_drop);
      if (exp_tv) begin
         chk("tagFirst", tagFirst, exp_tf);
         chk("tagLast", tagLast, exp_tl);
      end
      if (shiftValid) begin obs_amt.push_back(int'(shiftAmount)); obs_bcyc.push_back(cyc); end
      if (tagValid) begin
         obs_tf.push_back(int'(tagFirst)); obs_tl.push_back(int'(tagLast)); obs_tcyc.push_back(cyc);
      end
      if (dropped) obs_drop++;
      reset = rst; rulerValid = v; ruler = r;
      #1;
      m_ready = rst && (q.size() <= 1);
      chk("rulerReady", rulerReady, m_ready);
      if (!rulerReady) obs_rlow++;
      if (!rst) begin
         model_reset();
      end else begin
         acc = v && m_ready;
         pre = '{exp_sv, exp_bf, exp_bl};
         if (q.size() > 0) begin
            b = q.pop_front();
            exp_sv = 1; exp_in = b.held; exp_amt = b.amt; exp_bf = b.first; exp_bl = b.last;
         end else begin
            exp_sv = 0; exp_bf = 0; exp_bl = 0;
         end
         exp_drop = acc && (r == '0);
         if (acc && r != '0) begin
            lo = -1; hi = -1;
            for (int i = 0; i < W; i++) if (r[i]) begin if (lo < 0) lo = i; hi = i; end
            for (int i = 0; i < W; i++) if (r[i]) q.push_back('{r, i, i == lo, i == hi});
         end
         hist.push_back(pre);
         t = hist.pop_front();
         exp_tv = t.v; exp_tf = t.f; exp_tl = t.l;
      end
   endtask

   function automatic int at(input int arr[$], input int i);
      return (i < arr.size()) ? arr[i] : -1;
   endfunction

   initial begin
      int a04b[4];
      int s;
      logic [W-1:0] r;
      a04b = '{0, 1, 3, 6};
      reset = 1'b0; rulerValid = 1'b0; ruler = '0;
      model_reset();
      repeat (2) @(posedge clk);

      // reset held with a valid ruler presented
      clear_logs();
      repeat (3) cycle(1'b0, 1'b1, 13'h04B);
      chk("reset_ready_low", obs_rlow, 3);

      clear_logs();
      cycle(1'b1, 1'b1, 13'h04B);
      repeat (8) cycle(1'b1, 1'b0, '0);
      chk("x04b_reset_no_beat_before_accept", at(obs_bcyc, 0) > 0, 1);
      chk("x04b_beats", obs_amt.size(), 4);
      for (int i = 0; i < 4; i++) chk("x04b_amt", at(obs_amt, i), a04b[i]);
      chk("x04b_tags", obs_tf.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("x04b_tagfirst", at(obs_tf, i), (i == 0) ? 1 : 0);
         chk("x04b_taglast", at(obs_tl, i), (i == 3) ? 1 : 0);
      end
      chk("x04b_tag_delay", at(obs_tcyc, 0) - at(obs_bcyc, 0), 2);
      chk("x04b_beats_adjacent", at(obs_bcyc, 3) - at(obs_bcyc, 0), 3);

      clear_logs();
      cycle(1'b1, 1'b1, 13'h001);
      cycle(1'b1, 1'b1, 13'h1000);
      repeat (6) cycle(1'b1, 1'b0, '0);
      chk("b2b_beats", obs_amt.size(), 2);
      chk("b2b_amt0", at(obs_amt, 0), 0);
      chk("b2b_amt1", at(obs_amt, 1), 12);
      chk("b2b_no_gap", at(obs_bcyc, 1) - at(obs_bcyc, 0), 1);
      for (int i = 0; i < 2; i++) begin
         chk("b2b_tagfirst", at(obs_tf, i), 1);
         chk("b2b_taglast", at(obs_tl, i), 1);
      end

      clear_logs();
      cycle(1'b1, 1'b1, 13'h000);
      repeat (4) cycle(1'b1, 1'b0, '0);
      chk("zero_dropped_once", obs_drop, 1);
      chk("zero_no_beats", obs_amt.size(), 0);
      chk("zero_ready_stays", obs_rlow, 0);

      clear_logs();
      cycle(1'b1, 1'b1, 13'h1FFF);
      repeat (18) cycle(1'b1, 1'b0, '0);
      s = 0;
      foreach (obs_amt[i]) s += obs_amt[i];
      chk("full_beats", obs_amt.size(), 13);
      chk("full_amt_sum", s, 78);
      chk("full_last_amt", at(obs_amt, 12), 12);
      chk("full_ready_low", obs_rlow, 12);

      // reset lands on the edge after beat 1
      clear_logs();
      cycle(1'b1, 1'b1, 13'h04B);
      repeat (2) cycle(1'b1, 1'b0, '0);
      cycle(1'b0, 1'b0, '0);
      repeat (6) cycle(1'b1, 1'b0, '0);
      chk("rst_mid_beats", obs_amt.size(), 2);
      chk("rst_mid_no_tags", obs_tf.size(), 0);
      clear_logs();
      cycle(1'b1, 1'b1, 13'h04B);
      repeat (8) cycle(1'b1, 1'b0, '0);
      chk("rst_mid_restart_first", at(obs_tf, 0), 1);
      chk("rst_mid_restart_beats", obs_amt.size(), 4);

      for (int n = 0; n < 800; n++) begin
         case ($urandom_range(0, 3))
            0: r = '0;
            1: r = W'(1) << $urandom_range(0, W - 1);
            2: r = W'($urandom);
            default: r = W'($urandom) & W'($urandom) & W'($urandom);
         endcase
         cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 1) == 1), r);
      end
      repeat (20) cycle(1'b1, 1'b0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
